// File: rtl/d_e_pipe_reg.sv
// d_e_pipe_reg: D/E pipeline register of the 5-stage MIPS core.
// Captures the forwarded D-stage operands and decoded control bundle and
// presents them to the E stage. A load-use stall turns the next edge into a
// nop bubble. E_hold freezes the register and discards any pending bubble
// request, because the hazard unit keeps D stalled and asserts it again.
// The PC still advances into E on a bubble so traces show where it came from.
//
// Optional build macro: D_E_PERF_EN
//   Adds the perf_bubbles/perf_holds counters and a bubble trace line.
module d_e_pipe_reg #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          D_bubble,
  input  logic          E_hold,
  input  logic [DW-1:0] D_PC,
  input  logic [31:0]   D_Instr,
  input  logic [DW-1:0] D_V1,
  input  logic [DW-1:0] D_V2,
  input  logic [DW-1:0] D_Ext,
  input  logic [RW-1:0] D_A1,
  input  logic [RW-1:0] D_A2,
  input  logic [RW-1:0] D_A3,
  input  logic [2:0]    D_RegWrite,
  input  logic [TW-1:0] D_Tnew,
  output logic [DW-1:0] E_PC,
  output logic [31:0]   E_Instr,
  output logic [DW-1:0] E_V1,
  output logic [DW-1:0] E_V2,
  output logic [DW-1:0] E_Ext,
  output logic [RW-1:0] E_A1,
  output logic [RW-1:0] E_A2,
  output logic [RW-1:0] E_A3,
  output logic [2:0]    E_RegWrite,
  output logic [TW-1:0] E_Tnew,
  output logic          E_valid
`ifdef D_E_PERF_EN
  ,
  output logic [31:0]   perf_bubbles,
  output logic [31:0]   perf_holds
`endif
);

  logic [DW-1:0] pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [DW-1:0] v1_q, v1_d;
  logic [DW-1:0] v2_q, v2_d;
  logic [DW-1:0] ext_q, ext_d;
  logic [RW-1:0] a1_q, a1_d;
  logic [RW-1:0] a2_q, a2_d;
  logic [RW-1:0] a3_q, a3_d;
  logic [2:0]    regwrite_q, regwrite_d;
  logic [TW-1:0] tnew_q, tnew_d;
  logic          valid_q, valid_d;

  // Next-state selection: hold keeps everything, bubble inserts a nop, else load.
  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    v1_d       = v1_q;
    v2_d       = v2_q;
    ext_d      = ext_q;
    a1_d       = a1_q;
    a2_d       = a2_q;
    a3_d       = a3_q;
    regwrite_d = regwrite_q;
    tnew_d     = tnew_q;
    valid_d    = valid_q;
    if (!E_hold) begin
      pc_d = D_PC;
      if (D_bubble) begin
        // sll $0,$0,0 with no destination: never a forwarding source.
        instr_d    = '0;
        v1_d       = '0;
        v2_d       = '0;
        ext_d      = '0;
        a1_d       = '0;
        a2_d       = '0;
        a3_d       = '0;
        regwrite_d = '0;
        tnew_d     = '0;
        valid_d    = 1'b0;
      end else begin
        instr_d    = D_Instr;
        v1_d       = D_V1;
        v2_d       = D_V2;
        ext_d      = D_Ext;
        a1_d       = D_A1;
        a2_d       = D_A2;
        a3_d       = D_A3;
        regwrite_d = D_RegWrite;
        tnew_d     = D_Tnew;
        valid_d    = 1'b1;
      end
    end
  end

  // Pipeline register with synchronous reset taking priority over hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= '0;
      instr_q    <= '0;
      v1_q       <= '0;
      v2_q       <= '0;
      ext_q      <= '0;
      a1_q       <= '0;
      a2_q       <= '0;
      a3_q       <= '0;
      regwrite_q <= '0;
      tnew_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      ext_q      <= ext_d;
      a1_q       <= a1_d;
      a2_q       <= a2_d;
      a3_q       <= a3_d;
      regwrite_q <= regwrite_d;
      tnew_q     <= tnew_d;
      valid_q    <= valid_d;
    end
  end

  assign E_PC       = pc_q;
  assign E_Instr    = instr_q;
  assign E_V1       = v1_q;
  assign E_V2       = v2_q;
  assign E_Ext      = ext_q;
  assign E_A1       = a1_q;
  assign E_A2       = a2_q;
  assign E_A3       = a3_q;
  assign E_RegWrite = regwrite_q;
  assign E_Tnew     = tnew_q;
  assign E_valid    = valid_q;

`ifdef D_E_PERF_EN
  logic [31:0] bubbles_q, bubbles_d;
  logic [31:0] holds_q, holds_d;

  // Counter increments; a bubble request swallowed by a hold is not a bubble.
  always_comb begin
    bubbles_d = bubbles_q;
    holds_d   = holds_q;
    if (E_hold) begin
      holds_d = holds_q + 32'd1;
    end else if (D_bubble) begin
      bubbles_d = bubbles_q + 32'd1;
    end
  end

  // Performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubbles_q <= '0;
      holds_q   <= '0;
    end else begin
      bubbles_q <= bubbles_d;
      holds_q   <= holds_d;
    end
  end

  // Bubble trace in the same shape as the GRF write trace.
  always @(posedge clk) begin
    if (!reset && !E_hold && D_bubble) begin
      $display("%d@%h: D/E bubble", $time, D_PC);
    end
  end

  assign perf_bubbles = bubbles_q;
  assign perf_holds   = holds_q;
`endif

endmodule

// File: tb/tb_d_e_pipe_reg.sv
// Directed testbench for d_e_pipe_reg. Inputs change 1 time unit after the
// rising edge and outputs are sampled at the same point.
module tb_d_e_pipe_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        D_bubble, E_hold;
  logic [31:0] D_PC, D_Instr, D_V1, D_V2, D_Ext;
  logic [4:0]  D_A1, D_A2, D_A3;
  logic [2:0]  D_RegWrite;
  logic [1:0]  D_Tnew;
  logic [31:0] E_PC, E_Instr, E_V1, E_V2, E_Ext;
  logic [4:0]  E_A1, E_A2, E_A3;
  logic [2:0]  E_RegWrite;
  logic [1:0]  E_Tnew;
  logic        E_valid;
`ifdef D_E_PERF_EN
  logic [31:0] perf_bubbles, perf_holds;
`endif

  int checks = 0;
  int errors = 0;

  d_e_pipe_reg dut (
    .clk(clk), .reset(reset), .D_bubble(D_bubble), .E_hold(E_hold),
    .D_PC(D_PC), .D_Instr(D_Instr), .D_V1(D_V1), .D_V2(D_V2), .D_Ext(D_Ext),
    .D_A1(D_A1), .D_A2(D_A2), .D_A3(D_A3), .D_RegWrite(D_RegWrite), .D_Tnew(D_Tnew),
    .E_PC(E_PC), .E_Instr(E_Instr), .E_V1(E_V1), .E_V2(E_V2), .E_Ext(E_Ext),
    .E_A1(E_A1), .E_A2(E_A2), .E_A3(E_A3), .E_RegWrite(E_RegWrite), .E_Tnew(E_Tnew),
    .E_valid(E_valid)
`ifdef D_E_PERF_EN
    , .perf_bubbles(perf_bubbles), .perf_holds(perf_holds)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] ext, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] a3,
                       input logic [2:0] rw, input logic [1:0] tnew);
    D_PC = pc; D_Instr = instr; D_V1 = v1; D_V2 = v2; D_Ext = ext;
    D_A1 = a1; D_A2 = a2; D_A3 = a3; D_RegWrite = rw; D_Tnew = tnew;
  endtask

  task automatic test_reset;
    reset = 1'b1; D_bubble = 1'b0; E_hold = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_d($urandom, $urandom, $urandom, $urandom, $urandom,
            5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 2'($urandom));
      tick();
    end
    reset = 1'b0;
    checks++; if (E_PC !== 32'h0) begin errors++; $display("FAIL reset E_PC got %h exp 0", E_PC); end
    checks++; if (E_Instr !== 32'h0) begin errors++; $display("FAIL reset E_Instr got %h exp 0", E_Instr); end
    checks++; if (E_V1 !== 32'h0 || E_V2 !== 32'h0 || E_Ext !== 32'h0) begin
      errors++; $display("FAIL reset E_V1/V2/Ext got %h %h %h exp 0", E_V1, E_V2, E_Ext); end
    checks++; if (E_A1 !== 5'd0 || E_A2 !== 5'd0 || E_A3 !== 5'd0) begin
      errors++; $display("FAIL reset E_A1/A2/A3 got %0d %0d %0d exp 0", E_A1, E_A2, E_A3); end
    checks++; if (E_RegWrite !== 3'd0) begin errors++; $display("FAIL reset E_RegWrite got %0d exp 0", E_RegWrite); end
    checks++; if (E_Tnew !== 2'd0) begin errors++; $display("FAIL reset E_Tnew got %0d exp 0", E_Tnew); end
    checks++; if (E_valid !== 1'b0) begin errors++; $display("FAIL reset E_valid got %b exp 0", E_valid); end
  endtask

  task automatic test_load;
    set_d(32'h3000, 32'h8C220004, 32'h10, 32'h20, 32'h4, 5'd1, 5'd2, 5'd2, 3'd1, 2'd2);
    tick();
    checks++; if (E_PC !== 32'h3000) begin errors++; $display("FAIL load E_PC got %h exp 3000", E_PC); end
    checks++; if (E_Instr !== 32'h8C220004) begin errors++; $display("FAIL load E_Instr got %h exp 8c220004", E_Instr); end
    checks++; if (E_V1 !== 32'h10) begin errors++; $display("FAIL load E_V1 got %h exp 10", E_V1); end
    checks++; if (E_V2 !== 32'h20) begin errors++; $display("FAIL load E_V2 got %h exp 20", E_V2); end
    checks++; if (E_Ext !== 32'h4) begin errors++; $display("FAIL load E_Ext got %h exp 4", E_Ext); end
    checks++; if (E_A1 !== 5'd1 || E_A2 !== 5'd2) begin
      errors++; $display("FAIL load E_A1/A2 got %0d %0d exp 1 2", E_A1, E_A2); end
    checks++; if (E_A3 !== 5'd2) begin errors++; $display("FAIL load E_A3 got %0d exp 2", E_A3); end
    checks++; if (E_RegWrite !== 3'd1) begin errors++; $display("FAIL load E_RegWrite got %0d exp 1", E_RegWrite); end
    checks++; if (E_Tnew !== 2'd2) begin errors++; $display("FAIL load E_Tnew got %0d exp 2", E_Tnew); end
    checks++; if (E_valid !== 1'b1) begin errors++; $display("FAIL load E_valid got %b exp 1", E_valid); end
  endtask

  task automatic test_bubble;
    set_d(32'h3004, 32'h00431020, 32'h55, 32'h66, 32'h77, 5'd2, 5'd3, 5'd3, 3'd1, 2'd1);
    D_bubble = 1'b1;
    tick();
    D_bubble = 1'b0;
    checks++; if (E_PC !== 32'h3004) begin errors++; $display("FAIL bubble E_PC got %h exp 3004", E_PC); end
    checks++; if (E_Instr !== 32'h0) begin errors++; $display("FAIL bubble E_Instr got %h exp 0", E_Instr); end
    checks++; if (E_V1 !== 32'h0 || E_V2 !== 32'h0 || E_Ext !== 32'h0) begin
      errors++; $display("FAIL bubble E_V1/V2/Ext got %h %h %h exp 0", E_V1, E_V2, E_Ext); end
    checks++; if (E_A1 !== 5'd0 || E_A2 !== 5'd0 || E_A3 !== 5'd0) begin
      errors++; $display("FAIL bubble E_A1/A2/A3 got %0d %0d %0d exp 0", E_A1, E_A2, E_A3); end
    checks++; if (E_RegWrite !== 3'd0) begin errors++; $display("FAIL bubble E_RegWrite got %0d exp 0", E_RegWrite); end
    checks++; if (E_Tnew !== 2'd0) begin errors++; $display("FAIL bubble E_Tnew got %0d exp 0", E_Tnew); end
    checks++; if (E_valid !== 1'b0) begin errors++; $display("FAIL bubble E_valid got %b exp 0", E_valid); end
  endtask

  task automatic test_hold_beats_bubble;
    set_d(32'h3008, 32'h8C650008, 32'hA0, 32'hB0, 32'h8, 5'd3, 5'd5, 5'd5, 3'd1, 2'd2);
    tick();
    E_hold = 1'b1; D_bubble = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_d(32'h4000 + 32'(i * 4), 32'hDEAD0000 + 32'(i), 32'h111 * 32'(i + 1), 32'h1,
            32'h2, 5'd7, 5'd8, 5'd9, 3'd4, 2'd3);
      tick();
      checks++; if (E_PC !== 32'h3008 || E_Instr !== 32'h8C650008) begin
        errors++; $display("FAIL hold[%0d] E_PC/E_Instr got %h %h exp 3008 8c650008", i, E_PC, E_Instr); end
      checks++; if (E_V1 !== 32'hA0 || E_V2 !== 32'hB0 || E_Ext !== 32'h8) begin
        errors++; $display("FAIL hold[%0d] E_V1/V2/Ext got %h %h %h exp a0 b0 8", i, E_V1, E_V2, E_Ext); end
      checks++; if (E_A1 !== 5'd3 || E_A2 !== 5'd5 || E_A3 !== 5'd5 || E_RegWrite !== 3'd1) begin
        errors++; $display("FAIL hold[%0d] E_A1/A2/A3/RW got %0d %0d %0d %0d exp 3 5 5 1",
                           i, E_A1, E_A2, E_A3, E_RegWrite); end
      checks++; if (E_Tnew !== 2'd2 || E_valid !== 1'b1) begin
        errors++; $display("FAIL hold[%0d] E_Tnew/E_valid got %0d %b exp 2 1", i, E_Tnew, E_valid); end
    end
    E_hold = 1'b0; D_bubble = 1'b0;
    set_d(32'h300C, 32'h00A62021, 32'hC0, 32'hD0, 32'h0, 5'd5, 5'd6, 5'd4, 3'd2, 2'd1);
    tick();
    checks++; if (E_PC !== 32'h300C || E_Instr !== 32'h00A62021) begin
      errors++; $display("FAIL hold_release E_PC/E_Instr got %h %h exp 300c 00a62021", E_PC, E_Instr); end
    checks++; if (E_A3 !== 5'd4 || E_RegWrite !== 3'd2 || E_Tnew !== 2'd1 || E_valid !== 1'b1) begin
      errors++; $display("FAIL hold_release E_A3/RW/Tnew/valid got %0d %0d %0d %b exp 4 2 1 1",
                         E_A3, E_RegWrite, E_Tnew, E_valid); end
  endtask

  task automatic test_reset_mid_hold;
    E_hold = 1'b1; reset = 1'b1;
    set_d(32'h5000, 32'h12345678, 32'h9, 32'hA, 32'hB, 5'd10, 5'd11, 5'd12, 3'd3, 2'd1);
    tick();
    E_hold = 1'b0; reset = 1'b0;
    checks++; if (E_PC !== 32'h0 || E_Instr !== 32'h0 || E_V1 !== 32'h0) begin
      errors++; $display("FAIL reset_hold E_PC/Instr/V1 got %h %h %h exp 0", E_PC, E_Instr, E_V1); end
    checks++; if (E_A3 !== 5'd0 || E_RegWrite !== 3'd0 || E_Tnew !== 2'd0 || E_valid !== 1'b0) begin
      errors++; $display("FAIL reset_hold E_A3/RW/Tnew/valid got %0d %0d %0d %b exp 0",
                         E_A3, E_RegWrite, E_Tnew, E_valid); end
    tick();
    checks++; if (E_PC !== 32'h5000 || E_Instr !== 32'h12345678 || E_Ext !== 32'hB) begin
      errors++; $display("FAIL reset_hold_load E_PC/Instr/Ext got %h %h %h exp 5000 12345678 b",
                         E_PC, E_Instr, E_Ext); end
    checks++; if (E_A1 !== 5'd10 || E_A2 !== 5'd11 || E_A3 !== 5'd12 || E_valid !== 1'b1) begin
      errors++; $display("FAIL reset_hold_load E_A1/A2/A3/valid got %0d %0d %0d %b exp 10 11 12 1",
                         E_A1, E_A2, E_A3, E_valid); end
  endtask

  task automatic test_back_to_back;
    set_d(32'h6000, 32'h3C01FFFF, 32'hFFFFFFFF, 32'h0, 32'hFFFF0000, 5'd0, 5'd1, 5'd31, 3'd7, 2'd3);
    tick();
    checks++; if (E_V1 !== 32'hFFFFFFFF || E_Ext !== 32'hFFFF0000 || E_A3 !== 5'd31) begin
      errors++; $display("FAIL b2b0 E_V1/Ext/A3 got %h %h %0d exp ffffffff ffff0000 31", E_V1, E_Ext, E_A3); end
    checks++; if (E_RegWrite !== 3'd7 || E_Tnew !== 2'd3) begin
      errors++; $display("FAIL b2b0 E_RegWrite/Tnew got %0d %0d exp 7 3", E_RegWrite, E_Tnew); end
    set_d(32'h6004, 32'hAC220000, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd0, 3'd0, 2'd0);
    tick();
    checks++; if (E_PC !== 32'h6004 || E_V2 !== 32'h2 || E_A3 !== 5'd0) begin
      errors++; $display("FAIL b2b1 E_PC/V2/A3 got %h %h %0d exp 6004 2 0", E_PC, E_V2, E_A3); end
    checks++; if (E_RegWrite !== 3'd0 || E_Tnew !== 2'd0 || E_valid !== 1'b1) begin
      errors++; $display("FAIL b2b1 E_RegWrite/Tnew/valid got %0d %0d %b exp 0 0 1",
                         E_RegWrite, E_Tnew, E_valid); end
  endtask

`ifdef D_E_PERF_EN
  task automatic test_perf;
    reset = 1'b1; E_hold = 1'b0; D_bubble = 1'b0;
    tick();
    reset = 1'b0;
    checks++; if (perf_bubbles !== 32'd0 || perf_holds !== 32'd0) begin
      errors++; $display("FAIL perf_reset got %0d %0d exp 0 0", perf_bubbles, perf_holds); end
    D_bubble = 1'b1;
    for (int i = 0; i < 4; i++) begin D_PC = 32'h7000 + 32'(i * 4); tick(); end
    D_bubble = 1'b0; E_hold = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    D_bubble = 1'b1;
    tick();
    E_hold = 1'b0; D_bubble = 1'b0;
    tick();
    checks++; if (perf_bubbles !== 32'd4) begin
      errors++; $display("FAIL perf_bubbles got %0d exp 4", perf_bubbles); end
    checks++; if (perf_holds !== 32'd4) begin
      errors++; $display("FAIL perf_holds got %0d exp 4", perf_holds); end
  endtask
`endif

  initial begin
    reset = 1'b1; D_bubble = 1'b0; E_hold = 1'b0;
    set_d('0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
    test_reset();
    test_load();
    test_bubble();
    test_hold_beats_bubble();
    test_reset_mid_hold();
    test_back_to_back();
`ifdef D_E_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
